secure_jump_filter: RTL and testbench
=====================================

Name: secure_jump_filter

Overview:
- Single-stage registered instruction filter placed between instruction fetch and decode of the MIPS-style pipeline.
- Inspects the low 32-bit instruction word of each 64-bit fetch beat.
- Any J or JAL whose 26-bit target field equals the protected (secure) target is replaced by a NOP (0x00000000). All other instructions pass through unchanged.
- Counts squashed jumps for debug and security monitoring.

Parameters:
- DATA_W, 64, width of the fetch beat; only bits [31:0] carry the instruction.
- SEC_TARGET, 26'h0000000, protected jump target field value; jumps to it are squashed.
- CNT_W, 16, width of the saturating squash counter.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, filter enable; 0 means every instruction passes unmodified.
- in_valid, input, 1, upstream beat valid.
- in_ready, output, 1, stage can accept a beat.
- i, input, DATA_W, fetch beat; [31:0] is the instruction, [63:32] is sideband.
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts the beat.
- o, output, DATA_W, filtered beat.
- squashed, output, 1, the current output beat was a squashed jump.
- squash_cnt, output, CNT_W, saturating count of squashed jumps.

Behaviour:
- Reset (async assert, sync release): out_valid=0, o=0, squashed=0, squash_cnt=0.
- Opcode is i[31:26]. The J opcode is 6'h02 and the JAL opcode is 6'h03. The target field is i[25:0].
- Secure hit = en AND (opcode is J or JAL) AND (i[25:0] == SEC_TARGET).
- Output on a secure hit:
  - o[31:0] = 32'h00000000 (NOP).
  - o[63:32] = i[63:32].
  - squashed=1.
- Output when there is no hit: o = i, squashed=0.
- Handshake:
  - in_ready = !out_valid OR out_ready (combinational).
  - Beat is loaded when in_valid AND in_ready.
  - On load: o, squashed, and out_valid=1 are registered. Latency is 1 cycle from accept to out_valid.
  - No load AND out_ready: out_valid drops to 0. o and squashed hold their last value.
  - out_valid=1 AND out_ready=0: o and squashed are held stable and in_ready=0.
  - Simultaneous drain and load: back-to-back throughput of 1 beat per cycle.
- squash_cnt increments by 1 on every loaded beat with a secure hit. It saturates at all-ones and never wraps.
- Other opcodes (JR, branches, 6'h00 R-type) are never squashed, including opcode 6'h00 with zero fields.
- Reset asserted mid-stream discards the held beat immediately; out_valid falls asynchronously.

Decomposition:
- Shared package secjmp_pkg:
  - OPC_J = 6'h02.
  - OPC_JAL = 6'h03.
  - INSTR_NOP = 32'h00000000.
  - Field slice positions OPC_MSB=31, OPC_LSB=26, TGT_MSB=25.
- One combinational sub-module, jump_target_check.
  - Input: instruction word, en, secure target.
  - Output: hit.
- The top module holds the pipeline register, handshake, and counter.

Test Plan:
- Reset with rst_n=0, then release; keep en=1 and out_ready=1 throughout. Send i=32'h20210001 -> one cycle later o=32'h20210001, squashed=0, squash_cnt=0.
- Send i=32'h08000000 (J to secure target) -> o=32'h00000000, squashed=1, squash_cnt=1.
- Send i=32'h0800FACE (J elsewhere) -> o=32'h0800FACE, squashed=0, squash_cnt unchanged.
- Send i=32'h0C000000 (JAL secure), then i=32'h0C00FACE back-to-back:
  - First output: o=32'h00000000.
  - Second output: o=32'h0C00FACE.
  - squash_cnt increases by exactly 1.
- Repeat with en=0 and i=32'h08000000 -> o=32'h08000000, squashed=0. Then i=64'hDEADBEEF_0C000000 with en=1 -> o=64'hDEADBEEF_00000000.
- Backpressure: out_ready=0 while two beats are offered -> o stays stable and in_ready=0. Assert rst_n=0 mid-hold -> out_valid=0 and squash_cnt=0 immediately.

Source files
------------

// File: rtl/secure_jump_filter_pkg.sv
// -----------------------------------------------------------------------------
// secjmp_pkg
// Shared definitions for the secure jump filter: MIPS instruction field
// positions, the J/JAL opcodes, the NOP encoding and a jump-opcode helper.
// -----------------------------------------------------------------------------
package secjmp_pkg;

  localparam int INSTR_W = 32;

  // Instruction field slice positions (J-format: opcode | 26-bit target).
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int TGT_MSB = 25;
  localparam int TGT_W   = TGT_MSB + 1;

  typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;
  typedef logic [TGT_W-1:0]         target_t;

  localparam opcode_t               OPC_J     = 6'h02;
  localparam opcode_t               OPC_JAL   = 6'h03;
  localparam logic [INSTR_W-1:0]    INSTR_NOP = 32'h0000_0000;

  // True for the two absolute-target jumps; JR, branches and R-type are not.
  function automatic logic is_jump(input opcode_t opc);
    return (opc == OPC_J) || (opc == OPC_JAL);
  endfunction

endpackage : secjmp_pkg

// File: rtl/secure_jump_filter_if.sv
// -----------------------------------------------------------------------------
// secure_jump_filter_if
// Valid/ready stream bundle around the filter stage: the fetch-side input
// beat (in_valid/in_ready/i) and the decode-side output beat
// (out_valid/out_ready/o).
//   master : environment side - drives in_valid, i, out_ready
//   slave  : filter side      - drives in_ready, out_valid, o
// -----------------------------------------------------------------------------
interface secure_jump_filter_if #(
  parameter int DATA_W = 64
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] i;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] o;

  modport master (
    output in_valid,
    output i,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  o
  );

  modport slave (
    input  in_valid,
    input  i,
    input  out_ready,
    output in_ready,
    output out_valid,
    output o
  );

endinterface : secure_jump_filter_if

// File: rtl/secure_jump_filter_jump_target_check.sv
// -----------------------------------------------------------------------------
// jump_target_check
// Combinational detector: flags a J or JAL whose 26-bit target field equals
// the protected target, qualified by the filter enable.
//   instr_i      : 32-bit instruction word
//   en_i         : filter enable
//   sec_target_i : protected target field value
//   hit_o        : instruction must be squashed
// -----------------------------------------------------------------------------
module jump_target_check
  import secjmp_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               en_i,
  input  target_t            sec_target_i,
  output logic               hit_o
);

  opcode_t opcode;
  target_t target;

  assign opcode = instr_i[OPC_MSB:OPC_LSB];
  assign target = instr_i[TGT_MSB:0];

  assign hit_o = en_i && is_jump(opcode) && (target == sec_target_i);

endmodule : jump_target_check

// File: rtl/secure_jump_filter.sv
// -----------------------------------------------------------------------------
// secure_jump_filter
// Single registered stage between fetch and decode. The low 32 bits of each
// fetch beat are inspected; a J/JAL to the protected target is replaced by a
// NOP while the upper sideband bits pass through. Squashed jumps are counted
// in a saturating counter.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   en         : filter enable (0 = pass everything)
//   bus        : valid/ready input and output beats (slave side)
//   squashed   : current output beat is a squashed jump
//   squash_cnt : saturating count of squashed jumps
// -----------------------------------------------------------------------------
module secure_jump_filter
  import secjmp_pkg::*;
#(
  parameter int      DATA_W     = 64,
  parameter target_t SEC_TARGET = 26'h000_0000,
  parameter int      CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  secure_jump_filter_if.slave   bus,
  output logic                  squashed,
  output logic [CNT_W-1:0]      squash_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              hit;
  logic              load;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] o_q, o_d;
  logic              squashed_q, squashed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  jump_target_check u_check (
    .instr_i      (bus.i[INSTR_W-1:0]),
    .en_i         (en),
    .sec_target_i (SEC_TARGET),
    .hit_o        (hit)
  );

  // The stage is free when empty or when its current beat leaves this cycle,
  // which gives one beat per cycle when both sides are streaming.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;

  always_comb begin
    // NOTE: every next-state value gets a hold default first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    out_valid_d = out_valid_q;
    o_d         = o_q;
    squashed_d  = squashed_q;
    cnt_d       = cnt_q;

    if (load) begin
      out_valid_d = 1'b1;
      o_d         = bus.i;
      squashed_d  = hit;
      if (hit) begin
        o_d[INSTR_W-1:0] = INSTR_NOP;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else if (bus.out_ready) begin
      // Drained with nothing behind it: data and squashed keep their values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      o_q         <= '0;
      squashed_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      out_valid_q <= out_valid_d;
      o_q         <= o_d;
      squashed_q  <= squashed_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.o         = o_q;
  assign squashed      = squashed_q;
  assign squash_cnt    = cnt_q;

endmodule : secure_jump_filter

// File: tb/tb_secure_jump_filter.sv
// -----------------------------------------------------------------------------
// tb_secure_jump_filter
// Table of {enable, beat, expected beat, expected squashed} records streamed
// back-to-back through the filter; expectations are queued on acceptance and
// compared when the output beat is consumed. Hand-written sequences cover
// backpressure, asynchronous reset while holding, and counter saturation on a
// second instance with a narrow counter and a non-zero protected target.
// -----------------------------------------------------------------------------
module tb_secure_jump_filter;

  typedef struct {
    logic        en;
    logic [63:0] i;
    logic [63:0] exp_o;
    logic        exp_sq;
  } vec_t;

  typedef struct {
    logic [63:0] o;
    logic        sq;
  } exp_t;

  logic clk;
  logic rst_n;
  logic en;

  secure_jump_filter_if #(.DATA_W(64)) bus ();
  logic        squashed;
  logic [15:0] squash_cnt;

  secure_jump_filter_if #(.DATA_W(64)) bus_s ();
  logic        squashed_s;
  logic [2:0]  squash_cnt_s;

  secure_jump_filter #(
    .DATA_W     (64),
    .SEC_TARGET (26'h000_0000),
    .CNT_W      (16)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bus        (bus),
    .squashed   (squashed),
    .squash_cnt (squash_cnt)
  );

  secure_jump_filter #(
    .DATA_W     (64),
    .SEC_TARGET (26'h000_0ACE),
    .CNT_W      (3)
  ) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bus        (bus_s),
    .squashed   (squashed_s),
    .squash_cnt (squash_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   exp_cnt = 0;
  exp_t sb_q[$];
  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one beat; the expectation is queued once the beat is seen accepted.
  task automatic send(input logic en_v, input logic [63:0] data,
                      input logic [63:0] exp_o, input logic exp_sq);
    exp_t e;
    bit   ok = 1'b0;
    en           = en_v;
    bus.in_valid = 1'b1;
    bus.i        = data;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: beat %h not accepted within 20 cycles", data);
    end else begin
      e.o  = exp_o;
      e.sq = exp_sq;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int left;
    left = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !bus.out_valid) begin
        left = 0;
        break;
      end
      left = sb_q.size();
    end
    check("drain_pending", 64'(left), 64'd0);
  endtask

  // Output monitor: a beat is consumed at the edge after a cycle with
  // out_valid and out_ready both high; sampled on the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_beat: got o=%h with nothing expected", bus.o);
        end else begin
          e = sb_q.pop_front();
          if (e.sq) exp_cnt++;
          check("o", bus.o, e.o);
          check("squashed", 64'(squashed), 64'(e.sq));
          check("squash_cnt", 64'(squash_cnt), 64'(exp_cnt));
        end
      end
    end
  end

  initial begin : stimulus
    vecs[0]  = '{1'b1, 64'h0000_0000_2021_0001, 64'h0000_0000_2021_0001, 1'b0};
    vecs[1]  = '{1'b1, 64'h0000_0000_0800_0000, 64'h0000_0000_0000_0000, 1'b1};
    vecs[2]  = '{1'b1, 64'h0000_0000_0800_FACE, 64'h0000_0000_0800_FACE, 1'b0};
    vecs[3]  = '{1'b1, 64'h0000_0000_0C00_0000, 64'h0000_0000_0000_0000, 1'b1};
    vecs[4]  = '{1'b1, 64'h0000_0000_0C00_FACE, 64'h0000_0000_0C00_FACE, 1'b0};
    vecs[5]  = '{1'b0, 64'h0000_0000_0800_0000, 64'h0000_0000_0800_0000, 1'b0};
    vecs[6]  = '{1'b1, 64'hDEAD_BEEF_0C00_0000, 64'hDEAD_BEEF_0000_0000, 1'b1};
    vecs[7]  = '{1'b1, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0};
    vecs[8]  = '{1'b1, 64'h0000_0000_1000_0000, 64'h0000_0000_1000_0000, 1'b0};
    vecs[9]  = '{1'b1, 64'h0000_0000_0000_0008, 64'h0000_0000_0000_0008, 1'b0};
    vecs[10] = '{1'b1, 64'h0000_0000_0400_0000, 64'h0000_0000_0400_0000, 1'b0};
    vecs[11] = '{1'b1, 64'h0000_0000_0800_0001, 64'h0000_0000_0800_0001, 1'b0};
    vecs[12] = '{1'b1, 64'h0000_0000_0BFF_FFFF, 64'h0000_0000_0BFF_FFFF, 1'b0};
    vecs[13] = '{1'b1, 64'hCAFE_F00D_0800_0000, 64'hCAFE_F00D_0000_0000, 1'b1};
    vecs[14] = '{1'b0, 64'h0000_0000_0C00_0000, 64'h0000_0000_0C00_0000, 1'b0};

    rst_n          = 1'b0;
    en             = 1'b1;
    bus.in_valid   = 1'b0;
    bus.i          = '0;
    bus.out_ready  = 1'b1;
    bus_s.in_valid = 1'b0;
    bus_s.i        = '0;
    bus_s.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_o", bus.o, 64'd0);
    check("rst_squashed", 64'(squashed), 64'd0);
    check("rst_squash_cnt", 64'(squash_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Table vectors, streamed back-to-back.
    foreach (vecs[k]) send(vecs[k].en, vecs[k].i, vecs[k].exp_o, vecs[k].exp_sq);
    wait_drain();

    // Backpressure: hold a squashed beat while two more beats are offered.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(1'b1, 64'h0000_0000_0800_0000, 64'h0, 1'b1);
    bus.in_valid = 1'b1;
    bus.i        = 64'h0000_0000_0800_FACE;
    repeat (3) begin
      @(negedge clk);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_o", bus.o, 64'h0);
      check("hold_squashed", 64'(squashed), 64'd1);
    end
    bus.i = 64'h0000_0000_0C00_FACE;
    repeat (2) begin
      @(negedge clk);
      check("hold2_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold2_o", bus.o, 64'h0);
    end
    check("hold_squash_cnt", 64'(squash_cnt), 64'(exp_cnt + 1));

    // Asynchronous reset mid-hold, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_squash_cnt", 64'(squash_cnt), 64'd0);
    check("async_rst_o", bus.o, 64'h0);
    check("async_rst_squashed", 64'(squashed), 64'd0);
    bus.in_valid = 1'b0;
    sb_q.delete();
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(1'b1, 64'h0000_0000_0C00_0000, 64'h0, 1'b1);
    wait_drain();

    // Saturation on the narrow-counter instance (protected target 0x0ACE).
    @(posedge clk);
    #1;
    en             = 1'b1;
    bus_s.in_valid = 1'b1;
    bus_s.i        = 64'h0000_0000_0800_0ACE;
    repeat (3) @(posedge clk);
    #1;
    check("sat_cnt_3", 64'(squash_cnt_s), 64'd3);
    repeat (7) @(posedge clk);
    #1;
    check("sat_cnt_max", 64'(squash_cnt_s), 64'd7);
    check("sat_o", bus_s.o, 64'h0);
    check("sat_squashed", 64'(squashed_s), 64'd1);
    bus_s.i = 64'h0000_0000_0800_0000;
    @(posedge clk);
    #1;
    check("sat_other_tgt_o", bus_s.o, 64'h0000_0000_0800_0000);
    check("sat_other_tgt_squashed", 64'(squashed_s), 64'd0);
    check("sat_cnt_held", 64'(squash_cnt_s), 64'd7);
    bus_s.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_secure_jump_filter
